// File: rtl/red_pitaya_asg_seq.sv
// Descriptor sequencer for one ASG channel: buffers segment descriptors in a
// FIFO, pre-fills four playback slots, then refills each slot as the channel
// retires it. If the FIFO is empty when a slot retires, that slot replays and
// an underrun is recorded.
module red_pitaya_asg_seq #(
  parameter int unsigned RSZ        = 14,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         dac_clk_i,
  input  logic                         dac_rst_i,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic                         desc_valid_i,
  output logic                         desc_ready_o,
  input  logic [RSZ+16-1:0]            desc_start_i,
  input  logic [RSZ+16-1:0]            desc_end_i,
  input  logic [RSZ+16-1:0]            desc_step_i,
  input  logic [15:0]                  desc_ncyc_i,
  input  logic [13:0]                  desc_amp_i,
  input  logic [13:0]                  desc_dc_i,
  input  logic                         buf_done_i,
  output logic [4*(RSZ+16)-1:0]        set_start_all_o,
  output logic [4*(RSZ+16)-1:0]        set_end_all_o,
  output logic [4*(RSZ+16)-1:0]        set_step_all_o,
  output logic [63:0]                  set_ncyc_all_o,
  output logic [55:0]                  set_amp_all_o,
  output logic [55:0]                  set_dc_all_o,
  output logic                         ch_rst_o,
  output logic                         ch_trig_o,
  output logic                         underrun_o,
  output logic [15:0]                  underrun_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_o,
  output logic [1:0]                   state_o
);

  localparam int unsigned W    = RSZ + 16;
  localparam int unsigned NBUF = 4;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;

  typedef struct packed {
    logic [W-1:0] start_p;
    logic [W-1:0] end_p;
    logic [W-1:0] step_p;
    logic [15:0]  ncyc;
    logic [13:0]  amp;
    logic [13:0]  dc;
  } desc_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_ARM     = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t        state_q;
  desc_t         fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  desc_t         slot_q [NBUF];
  logic [1:0]    wr_slot_q, rd_slot_q;
  logic          underrun_q;
  logic [15:0]   underrun_cnt_q;

  desc_t desc_in;
  desc_t head;
  logic  fifo_empty;
  logic  push;
  logic  pop;

  assign desc_in    = '{start_p: desc_start_i, end_p: desc_end_i, step_p: desc_step_i,
                        ncyc: desc_ncyc_i, amp: desc_amp_i, dc: desc_dc_i};
  assign head       = fifo_q[rptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign desc_ready_o = (cnt_q < CW'(FIFO_DEPTH));
  assign push       = desc_valid_i & desc_ready_o;
  // stop_i wins over any slot load; pops only feed a slot write
  assign pop        = ~stop_i & ~fifo_empty &
                      ((state_q == S_PREFILL) | ((state_q == S_RUN) & buf_done_i));

  // FIFO pointers and occupancy; a push is never forwarded to a same-cycle pop
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage, data only
  always_ff @(posedge dac_clk_i) begin
    if (push) fifo_q[wptr_q] <= desc_in;
  end

  // Sequencer FSM with slot and underrun bookkeeping
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q        <= S_IDLE;
      wr_slot_q      <= '0;
      rd_slot_q      <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      for (int k = 0; k < NBUF; k++) slot_q[k] <= '0;
    end else if (stop_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q        <= S_PREFILL;
            wr_slot_q      <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
          end
        end
        S_PREFILL: begin
          if (pop) begin
            slot_q[wr_slot_q] <= head;
            wr_slot_q         <= wr_slot_q + 2'd1;
            if (wr_slot_q == 2'd3) state_q <= S_ARM;
          end
        end
        S_ARM: begin
          state_q   <= S_RUN;
          rd_slot_q <= '0;
        end
        S_RUN: begin
          if (buf_done_i) begin
            rd_slot_q <= rd_slot_q + 2'd1;
            if (pop) begin
              slot_q[rd_slot_q] <= head;
            end else begin
              underrun_q <= 1'b1;
              if (underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the channel controls from the state register
  assign ch_rst_o       = (state_q == S_IDLE) | (state_q == S_PREFILL);
  assign ch_trig_o      = (state_q == S_ARM);
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = underrun_cnt_q;
  assign fifo_cnt_o     = cnt_q;
  assign state_o        = state_q;

  // Flatten slot registers onto the packed per-field buses
  for (genvar k = 0; k < NBUF; k++) begin : g_pack
    assign set_start_all_o[W*k +: W] = slot_q[k].start_p;
    assign set_end_all_o[W*k +: W]   = slot_q[k].end_p;
    assign set_step_all_o[W*k +: W]  = slot_q[k].step_p;
    assign set_ncyc_all_o[16*k +: 16] = slot_q[k].ncyc;
    assign set_amp_all_o[14*k +: 14]  = slot_q[k].amp;
    assign set_dc_all_o[14*k +: 14]   = slot_q[k].dc;
  end

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// Scoreboard bench for red_pitaya_asg_seq: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_red_pitaya_asg_seq;

  localparam int unsigned RSZ = 14;
  localparam int unsigned FD  = 8;
  localparam int unsigned W   = RSZ + 16;
  localparam int unsigned CW  = $clog2(FD) + 1;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] e;
    logic [W-1:0] st;
    logic [15:0]  n;
    logic [13:0]  a;
    logic [13:0]  d;
  } desc_t;

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0, valid = 1'b0, buf_done = 1'b0;
  logic              ready;
  desc_t             din = '0;
  logic [4*W-1:0]    set_start, set_end, set_step;
  logic [63:0]       set_ncyc;
  logic [55:0]       set_amp, set_dc;
  logic              ch_rst, ch_trig, underrun;
  logic [15:0]       underrun_cnt;
  logic [CW-1:0]     fifo_cnt;
  logic [1:0]        state;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  red_pitaya_asg_seq #(.RSZ(RSZ), .FIFO_DEPTH(FD)) dut (
    .dac_clk_i       (clk),
    .dac_rst_i       (rst),
    .start_i         (start),
    .stop_i          (stop),
    .desc_valid_i    (valid),
    .desc_ready_o    (ready),
    .desc_start_i    (din.s),
    .desc_end_i      (din.e),
    .desc_step_i     (din.st),
    .desc_ncyc_i     (din.n),
    .desc_amp_i      (din.a),
    .desc_dc_i       (din.d),
    .buf_done_i      (buf_done),
    .set_start_all_o (set_start),
    .set_end_all_o   (set_end),
    .set_step_all_o  (set_step),
    .set_ncyc_all_o  (set_ncyc),
    .set_amp_all_o   (set_amp),
    .set_dc_all_o    (set_dc),
    .ch_rst_o        (ch_rst),
    .ch_trig_o       (ch_trig),
    .underrun_o      (underrun),
    .underrun_cnt_o  (underrun_cnt),
    .fifo_cnt_o      (fifo_cnt),
    .state_o         (state)
  );

  // Descriptor n: start = n<<16, other fields distinct per n
  function automatic desc_t mk(int n);
    desc_t r;
    r.s  = W'(n << 16);
    r.e  = W'((n << 16) | 32'h8000);
    r.st = W'(32'h100 * (n + 1));
    r.n  = 16'(n * 3 + 1);
    r.a  = 14'(n * 5 + 7);
    r.d  = 14'h3FFF - 14'(n);
    return r;
  endfunction

  function automatic logic [31:0] actual(int id);
    int k = id % 10;
    case (id / 10)
      0: case (k)
           0: return 32'(state);
           1: return 32'(ch_rst);
           2: return 32'(ch_trig);
           3: return 32'(underrun);
           4: return 32'(underrun_cnt);
           5: return 32'(fifo_cnt);
           default: return 32'(ready);
         endcase
      1: return 32'(set_start[W*k +: W]);
      2: return 32'(set_end[W*k +: W]);
      3: return 32'(set_step[W*k +: W]);
      4: return 32'(set_ncyc[16*k +: 16]);
      5: return 32'(set_amp[14*k +: 14]);
      6: return 32'(set_dc[14*k +: 14]);
      default: return '1;
    endcase
  endfunction

  function automatic string sig_name(int id);
    string st [7] = '{"state_o", "ch_rst_o", "ch_trig_o", "underrun_o",
                      "underrun_cnt_o", "fifo_cnt_o", "desc_ready_o"};
    string sl [7] = '{"", "start", "end", "step", "ncyc", "amp", "dc"};
    if (id < 10) return st[id];
    return $sformatf("slot%0d_%s", id % 10, sl[id / 10]);
  endfunction

  // Monitor: every negedge, check all queued expectations
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = actual(e.id);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s at %0t: got 0x%0h want 0x%0h", sig_name(e.id), $time, act, e.val);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(int id, logic [31:0] v);
    exp_q.push_back('{id, v});
  endtask

  task automatic ex_slot(int k, desc_t d);
    ex(10 + k, 32'(d.s));
    ex(20 + k, 32'(d.e));
    ex(30 + k, 32'(d.st));
    ex(40 + k, 32'(d.n));
    ex(50 + k, 32'(d.a));
    ex(60 + k, 32'(d.d));
  endtask

  task automatic ex_status(int st, int cr, int tr, int ur, int uc, int fc, int rd);
    ex(0, 32'(st)); ex(1, 32'(cr)); ex(2, 32'(tr)); ex(3, 32'(ur));
    ex(4, 32'(uc)); ex(5, 32'(fc)); ex(6, 32'(rd));
  endtask

  task automatic push(int n);
    valid = 1'b1;
    din   = mk(n);
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_done();
    buf_done = 1'b1;
    tick();
    buf_done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    tick();
    ex_status(0, 1, 0, 0, 0, 0, 1);
    ex_slot(0, '0);

    // Push 6, start, prefill 4, ARM one cycle, RUN
    for (int n = 0; n < 6; n++) push(n);
    ex(5, 6);
    do_start();
    ex(0, 1); ex(1, 1); ex(5, 6);
    tick(); ex(0, 1); ex(10, 32'(mk(0).s)); ex(5, 5);
    tick(); ex(0, 1); ex(2, 0);
    tick(); ex(0, 1); ex(1, 1);
    tick(); ex_status(2, 0, 1, 0, 0, 2, 1);
    tick(); ex(0, 3); ex(1, 0); ex(2, 0);
    for (int k = 0; k < 4; k++) ex_slot(k, mk(k));

    // Refill slots 0 and 1 from the remaining two descriptors
    pulse_done(); ex_slot(0, mk(4)); ex(5, 1);
    pulse_done(); ex_slot(1, mk(5)); ex(5, 0); ex_slot(2, mk(2));
    // start_i ignored outside IDLE
    do_start(); ex(0, 3); ex(3, 0);

    // Underruns: fresh run with empty FIFO
    do_stop(); ex(0, 0); ex(1, 1); ex(5, 0);
    for (int n = 6; n < 10; n++) push(n);
    do_start();
    repeat (4) tick();
    ex(0, 2);
    tick(); ex(0, 3); ex(5, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_done(); ex(3, 1); ex(4, 32'(i));
    end
    for (int k = 0; k < 4; k++) ex_slot(k, mk(6 + k));
    push(10); ex(5, 1);
    pulse_done(); ex_slot(3, mk(10)); ex(5, 0); ex(4, 3);
    // Saturate the underrun counter
    buf_done = 1'b1;
    repeat (65540) tick();
    buf_done = 1'b0;
    ex(4, 32'hFFFF); ex(3, 1); ex_slot(0, mk(6));

    // Stop retains underrun status; fill the FIFO
    do_stop(); ex(0, 0); ex(1, 1); ex(3, 1); ex(4, 32'hFFFF);
    for (int n = 20; n < 28; n++) push(n);
    ex(5, 8); ex(6, 0);
    push(28); ex(5, 8); ex(6, 0);
    do_start(); ex_status(1, 1, 0, 0, 0, 8, 0);
    tick(); ex_slot(0, mk(20)); ex(5, 7); ex(6, 1);
    push(29); ex_slot(1, mk(21)); ex(5, 7);
    tick(); ex_slot(2, mk(22)); ex(5, 6);
    tick(); ex_slot(3, mk(23)); ex(5, 5); ex(0, 2);
    tick(); ex(0, 3);

    // stop_i together with buf_done_i: no slot load, no pop
    stop = 1'b1; buf_done = 1'b1;
    tick();
    stop = 1'b0; buf_done = 1'b0;
    ex(0, 0); ex(1, 1); ex(5, 5); ex_slot(0, mk(20));
    // buf_done_i ignored in IDLE
    pulse_done(); ex(5, 5); ex_slot(0, mk(20));

    // FIFO order check: the rejected 9th descriptor must not appear
    do_start();
    repeat (4) tick();
    ex(0, 2); ex(5, 1);
    for (int k = 0; k < 4; k++) ex_slot(k, mk(24 + k));
    tick();
    pulse_done(); ex_slot(0, mk(29)); ex(5, 0);

    // Reset mid-PREFILL after two slot writes
    do_stop();
    for (int n = 40; n < 44; n++) push(n);
    do_start();
    tick(); tick();
    ex(0, 1); ex_slot(1, mk(41));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_status(0, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) ex_slot(k, '0);
    tick();
    ex_status(0, 1, 0, 0, 0, 0, 1);
    tick();

    // Direct post-reset checks
    total++;
    if (state !== 2'd0) begin
      bad++;
      $display("FAIL state_o after reset: got %0d want 0", state);
    end
    total++;
    if (ch_rst !== 1'b1) begin
      bad++;
      $display("FAIL ch_rst_o after reset: got %0b want 1", ch_rst);
    end
    total++;
    if (fifo_cnt !== CW'(0)) begin
      bad++;
      $display("FAIL fifo_cnt_o after reset: got %0d want 0", fifo_cnt);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL desc_ready_o after reset: got %0b want 1", ready);
    end
    total++;
    if (set_start[W*0 +: W] !== W'(0) || set_start[W*1 +: W] !== W'(0)) begin
      bad++;
      $display("FAIL slot0/1 start after reset: got 0x%0h / 0x%0h want 0",
               set_start[W*0 +: W], set_start[W*1 +: W]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad != 0) $display("TEST FAILED");
    else          $display("TEST PASSED");
    $finish;
  end

endmodule
